// File: rtl/key_search_core.sv
// Key-range search controller: launches one datapath run per key and stops
// on the first pass, range exhaustion or abort; re-armable without reset.
module key_search_core #(
  parameter int KEY_WIDTH = 22,
  parameter int STRIDE    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [KEY_WIDTH-1:0] key_first,
  input  logic [KEY_WIDTH-1:0] key_last,
  output logic                 dp_start,
  output logic [KEY_WIDTH-1:0] dp_key,
  input  logic                 dp_done,
  input  logic                 dp_pass,
  output logic                 dp_done_ack,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic [KEY_WIDTH-1:0] key_found,
  output logic                 exhausted,
  output logic                 aborted,
  output logic [KEY_WIDTH:0]   keys_tried
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RELEASE,
    DONE
  } state_t;

  localparam logic [KEY_WIDTH:0] STEP = (KEY_WIDTH+1)'(STRIDE);

  state_t               state;
  state_t               state_nx;
  logic [KEY_WIDTH-1:0] last;
  logic [KEY_WIDTH-1:0] last_nx;
  logic                 pend;
  logic                 pend_nx;
  logic                 abort_hit;
  logic [KEY_WIDTH:0]   next_key;

  logic                 dp_start_nx;
  logic [KEY_WIDTH-1:0] dp_key_nx;
  logic                 ack_nx;
  logic                 busy_nx;
  logic                 done_nx;
  logic                 found_nx;
  logic [KEY_WIDTH-1:0] key_found_nx;
  logic                 exhausted_nx;
  logic                 aborted_nx;
  logic [KEY_WIDTH:0]   tried_nx;

  // One extra bit so a stride past the top of the key space cannot wrap.
  assign next_key  = {1'b0, dp_key} + STEP;
  assign abort_hit = pend | abort;

  always_comb begin
    state_nx     = state;
    last_nx      = last;
    pend_nx      = pend;
    dp_start_nx  = dp_start;
    dp_key_nx    = dp_key;
    ack_nx       = 1'b0;
    found_nx     = found;
    key_found_nx = key_found;
    exhausted_nx = exhausted;
    aborted_nx   = aborted;
    tried_nx     = keys_tried;

    unique case (state)
      IDLE: begin
        pend_nx = 1'b0;
        if (start && !dp_done) begin
          last_nx      = key_last;
          found_nx     = 1'b0;
          exhausted_nx = 1'b0;
          aborted_nx   = 1'b0;
          tried_nx     = '0;
          if (key_first > key_last) begin
            exhausted_nx = 1'b1;
            state_nx     = DONE;
          end else begin
            dp_key_nx   = key_first;
            dp_start_nx = 1'b1;
            state_nx    = RUN;
          end
        end
      end

      RUN: begin
        pend_nx = abort_hit;
        if (dp_done) begin
          ack_nx      = 1'b1;
          dp_start_nx = 1'b0;
          tried_nx    = keys_tried + 1'b1;
          if (dp_pass) begin
            found_nx     = 1'b1;
            key_found_nx = dp_key;
            state_nx     = DONE;
          end else if (abort_hit) begin
            aborted_nx = 1'b1;
            state_nx   = DONE;
          end else if (next_key > {1'b0, last}) begin
            exhausted_nx = 1'b1;
            state_nx     = DONE;
          end else begin
            state_nx = RELEASE;
          end
        end
      end

      RELEASE: begin
        pend_nx = abort_hit;
        if (abort_hit) begin
          aborted_nx = 1'b1;
          state_nx   = DONE;
        end else if (!dp_done) begin
          dp_key_nx   = next_key[KEY_WIDTH-1:0];
          dp_start_nx = 1'b1;
          state_nx    = RUN;
        end
      end

      DONE: begin
        if (!start) begin
          pend_nx  = 1'b0;
          state_nx = IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx == RUN) || (state_nx == RELEASE);
    done_nx = (state_nx == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last        <= '0;
      pend        <= 1'b0;
      dp_start    <= 1'b0;
      dp_key      <= '0;
      dp_done_ack <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      key_found   <= '0;
      exhausted   <= 1'b0;
      aborted     <= 1'b0;
      keys_tried  <= '0;
    end else begin
      state       <= state_nx;
      last        <= last_nx;
      pend        <= pend_nx;
      dp_start    <= dp_start_nx;
      dp_key      <= dp_key_nx;
      dp_done_ack <= ack_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      found       <= found_nx;
      key_found   <= key_found_nx;
      exhausted   <= exhausted_nx;
      aborted     <= aborted_nx;
      keys_tried  <= tried_nx;
    end
  end

endmodule

// File: tb/tb_key_search_core.sv
// Scoreboard bench for key_search_core: stride-1 and stride-4 instances,
// each driving a latency-modelled datapath.
module tb_key_search_core;

  localparam int KW = 8;

  typedef struct packed {
    logic          found;
    logic [KW-1:0] key;
    logic          exh;
    logic          abt;
    logic [KW:0]   tried;
  } res_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          abort = 1'b0;
  logic          start_v [2];
  logic [KW-1:0] key_first;
  logic [KW-1:0] key_last;

  logic          dp_start [2];
  logic [KW-1:0] dp_key [2];
  logic          dp_done [2];
  logic          dp_pass [2];
  logic          dp_done_ack [2];
  logic          busy [2];
  logic          done [2];
  logic          found [2];
  logic [KW-1:0] key_found [2];
  logic          exhausted [2];
  logic          aborted [2];
  logic [KW:0]   keys_tried [2];

  logic          pass_en = 1'b0;
  logic [KW-1:0] pass_key = '0;
  int            lat = 5;

  int            n_tests = 0;
  int            n_fail = 0;
  logic [KW-1:0] exp_keys [$];
  res_t          exp_res [$];

  always #5 clk = ~clk;

  key_search_core #(.KEY_WIDTH(KW), .STRIDE(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_v[0]), .abort(abort),
    .key_first(key_first), .key_last(key_last),
    .dp_start(dp_start[0]), .dp_key(dp_key[0]),
    .dp_done(dp_done[0]), .dp_pass(dp_pass[0]),
    .dp_done_ack(dp_done_ack[0]), .busy(busy[0]), .done(done[0]),
    .found(found[0]), .key_found(key_found[0]),
    .exhausted(exhausted[0]), .aborted(aborted[0]),
    .keys_tried(keys_tried[0])
  );

  key_search_core #(.KEY_WIDTH(KW), .STRIDE(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start_v[1]), .abort(abort),
    .key_first(key_first), .key_last(key_last),
    .dp_start(dp_start[1]), .dp_key(dp_key[1]),
    .dp_done(dp_done[1]), .dp_pass(dp_pass[1]),
    .dp_done_ack(dp_done_ack[1]), .busy(busy[1]), .done(done[1]),
    .found(found[1]), .key_found(key_found[1]),
    .exhausted(exhausted[1]), .aborted(aborted[1]),
    .keys_tried(keys_tried[1])
  );

  for (genvar g = 0; g < 2; g++) begin : g_dp
    logic run_r;
    logic done_r;
    logic pass_r;
    int   cnt;
    assign dp_done[g] = done_r;
    assign dp_pass[g] = pass_r;
    always @(posedge clk or posedge reset) begin
      if (reset) begin
        run_r  <= 1'b0;
        done_r <= 1'b0;
        pass_r <= 1'b0;
        cnt    <= 0;
      end else if (done_r && dp_done_ack[g]) begin
        done_r <= 1'b0;
        pass_r <= 1'b0;
      end else if (run_r) begin
        if (cnt <= 1) begin
          run_r  <= 1'b0;
          done_r <= 1'b1;
          pass_r <= pass_en && (dp_key[g] == pass_key);
        end else begin
          cnt <= cnt - 1;
        end
      end else if (dp_start[g] && !done_r) begin
        run_r <= 1'b1;
        cnt   <= lat;
      end
    end
  end

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] outs(input int i);
    return {dp_start[i], dp_key[i], dp_done_ack[i], busy[i], done[i],
            found[i], key_found[i], exhausted[i], aborted[i],
            keys_tried[i]};
  endfunction

  function automatic res_t mk(input logic f, input logic [KW-1:0] k,
                              input logic e, input logic a,
                              input logic [KW:0] t);
    res_t r;
    r.found = f;
    r.key   = k;
    r.exh   = e;
    r.abt   = a;
    r.tried = t;
    return r;
  endfunction

  task automatic monitor();
    logic          ps [2];
    logic          pa [2];
    logic          pd [2];
    logic [KW-1:0] pk [2];
    for (int i = 0; i < 2; i++) begin
      ps[i] = 1'b0;
      pa[i] = 1'b0;
      pd[i] = 1'b0;
      pk[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (dp_start[i] && !ps[i]) begin
          if (exp_keys.size() == 0) begin
            chk(1'b0, "launch_unexpected", 32'(dp_key[i]), 0);
          end else begin
            logic [KW-1:0] e;
            e = exp_keys.pop_front();
            chk(dp_key[i] == e, "launch_key", 32'(dp_key[i]), 32'(e));
          end
        end
        if (dp_start[i] && ps[i])
          chk(dp_key[i] == pk[i], "key_stable", 32'(dp_key[i]), 32'(pk[i]));
        if (pa[i])
          chk(!dp_done_ack[i], "ack_width", 32'(dp_done_ack[i]), 0);
        if (done[i] && !pd[i]) begin
          if (exp_res.size() == 0) begin
            chk(1'b0, "result_unexpected", outs(i), 0);
          end else begin
            res_t e;
            res_t a;
            e = exp_res.pop_front();
            a = mk(found[i], key_found[i], exhausted[i], aborted[i],
                   keys_tried[i]);
            chk({a.found, a.exh, a.abt, a.tried} ==
                {e.found, e.exh, e.abt, e.tried},
                "result_flags", 32'(a), 32'(e));
            if (e.found)
              chk(a.key == e.key, "result_key", 32'(a.key), 32'(e.key));
          end
        end
        ps[i] = dp_start[i];
        pa[i] = dp_done_ack[i];
        pd[i] = done[i];
        pk[i] = dp_key[i];
      end
    end
  endtask

  task automatic wait_done(input int idx);
    int n = 0;
    while (!done[idx] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(done[idx], "done_timeout", 32'(done[idx]), 1);
  endtask

  task automatic wait_launch(input int idx, input logic [KW-1:0] k);
    int n = 0;
    while (!(dp_start[idx] && dp_key[idx] == k) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(dp_start[idx] && dp_key[idx] == k, "launch_timeout",
        32'(dp_key[idx]), 32'(k));
  endtask

  task automatic run(input int idx, input logic [KW-1:0] f,
                     input logic [KW-1:0] l, input logic pe,
                     input logic [KW-1:0] pk, input int abk);
    pass_en   = pe;
    pass_key  = pk;
    key_first = f;
    key_last  = l;
    @(negedge clk);
    start_v[idx] = 1'b1;
    if (abk >= 0) begin
      wait_launch(idx, KW'(abk));
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    wait_done(idx);
    repeat (3) @(negedge clk);
    chk(done[idx] && !busy[idx], "done_hold", 32'({done[idx], busy[idx]}), 2);
    start_v[idx] = 1'b0;
    @(negedge clk);
    chk(!done[idx] && !busy[idx], "done_drop", 32'({done[idx], busy[idx]}), 0);
    chk(exp_keys.size() == 0 && exp_res.size() == 0, "queues_drained",
        32'(exp_keys.size() + exp_res.size()), 0);
  endtask

  task automatic stimulus();
    repeat (2) @(negedge clk);
    chk(outs(0) == 0, "reset_state_s1", outs(0), 0);
    chk(outs(1) == 0, "reset_state_s4", outs(1), 0);
    reset = 1'b0;
    @(negedge clk);

    // pass at key 5 of 3..6
    exp_keys.push_back(8'd3);
    exp_keys.push_back(8'd4);
    exp_keys.push_back(8'd5);
    exp_res.push_back(mk(1'b1, 8'd5, 1'b0, 1'b0, 9'd3));
    run(0, 8'd3, 8'd6, 1'b1, 8'd5, -1);

    // 0..3 never passes
    exp_keys.push_back(8'd0);
    exp_keys.push_back(8'd1);
    exp_keys.push_back(8'd2);
    exp_keys.push_back(8'd3);
    exp_res.push_back(mk(1'b0, 8'd0, 1'b1, 1'b0, 9'd4));
    run(0, 8'd0, 8'd3, 1'b0, 8'd0, -1);

    // stride 4 near the top must not wrap
    exp_keys.push_back(8'd250);
    exp_keys.push_back(8'd254);
    exp_res.push_back(mk(1'b0, 8'd0, 1'b1, 1'b0, 9'd2));
    run(1, 8'd250, 8'd255, 1'b0, 8'd0, -1);

    // top key with stride 1
    exp_keys.push_back(8'd254);
    exp_keys.push_back(8'd255);
    exp_res.push_back(mk(1'b0, 8'd0, 1'b1, 1'b0, 9'd2));
    run(0, 8'd254, 8'd255, 1'b0, 8'd0, -1);

    // empty range
    exp_res.push_back(mk(1'b0, 8'd0, 1'b1, 1'b0, 9'd0));
    key_first = 8'd9;
    key_last  = 8'd2;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    chk(done[0] && !dp_start[0] && !busy[0], "empty_range_done",
        32'({done[0], dp_start[0], busy[0]}), 4);
    start_v[0] = 1'b0;
    @(negedge clk);
    chk(!done[0], "empty_range_idle", 32'(done[0]), 0);

    // abort during key 1
    exp_keys.push_back(8'd0);
    exp_keys.push_back(8'd1);
    exp_res.push_back(mk(1'b0, 8'd0, 1'b0, 1'b1, 9'd2));
    run(0, 8'd0, 8'd100, 1'b0, 8'd0, 1);

    // abort during key 1 which passes
    exp_keys.push_back(8'd0);
    exp_keys.push_back(8'd1);
    exp_res.push_back(mk(1'b1, 8'd1, 1'b0, 1'b0, 9'd2));
    run(0, 8'd0, 8'd100, 1'b1, 8'd1, 1);

    // reset while key 7 is in flight
    for (int k = 0; k < 8; k++) exp_keys.push_back(KW'(k));
    pass_en   = 1'b0;
    key_first = 8'd0;
    key_last  = 8'd100;
    @(negedge clk);
    start_v[0] = 1'b1;
    wait_launch(0, 8'd7);
    #2 reset = 1'b1;
    #1 chk(outs(0) == 0, "reset_mid_run", outs(0), 0);
    @(negedge clk);
    start_v[0] = 1'b0;
    reset = 1'b0;
    chk(exp_keys.size() == 0, "pre_reset_launches", 32'(exp_keys.size()), 0);

    exp_keys.push_back(8'd0);
    exp_keys.push_back(8'd1);
    exp_res.push_back(mk(1'b0, 8'd0, 1'b1, 1'b0, 9'd2));
    run(0, 8'd0, 8'd1, 1'b0, 8'd0, -1);

    repeat (5) @(negedge clk);
  endtask

  initial begin
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    key_first  = '0;
    key_last   = '0;
    fork
      monitor();
      stimulus();
    join_any
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_search_core.md
# key_search_core

Parametrised key-search controller that sweeps a range of keys through one decryption datapath. It launches one datapath run per key over a start/done/ack handshake and stops on the first passing key, on range exhaustion, or on abort. Several instances with different `key_first` offsets and a shared `STRIDE` split the key space across parallel datapaths. Unlike the single-shot core, it iterates over keys, reports the result, and can be re-armed without a reset.

## Interface

Parameters:
- `KEY_WIDTH`, default 22: width of the key, the range bounds and the tried-key counter.
- `STRIDE`, default 1: increment between successive keys; must be at least 1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  level request to begin a search.
- `abort`  in  1  single-cycle request to stop after the current key.
- `key_first`  in  KEY_WIDTH  first key, sampled when `start` is accepted.
- `key_last`  in  KEY_WIDTH  inclusive upper bound, sampled when `start` is accepted.
- `dp_start`  out  1  level launch to the datapath; held high while a key is in flight.
- `dp_key`  out  KEY_WIDTH  key presented to the datapath.
- `dp_done`  in  1  datapath finished; held high until acknowledged.
- `dp_pass`  in  1  result for the key; valid while `dp_done` is high.
- `dp_done_ack`  out  1  one-cycle acknowledge of `dp_done`.
- `busy`  out  1  high in RUN and RELEASE.
- `done`  out  1  high in DONE.
- `found`  out  1  a passing key was found.
- `key_found`  out  KEY_WIDTH  the passing key; valid when `found` is high.
- `exhausted`  out  1  the range ended with no pass.
- `aborted`  out  1  the search was stopped by `abort`.
- `keys_tried`  out  KEY_WIDTH+1  number of keys acknowledged in this search.

## Operation

States are IDLE, RUN, RELEASE and DONE. All outputs are registered.

- **Reset.** Goes to IDLE. Every output is 0, including `dp_key` and `keys_tried`.
- **IDLE.**
  - Accepts a search when `start` is high and `dp_done` is low.
  - On accept: captures the bounds, clears `found`, `exhausted`, `aborted` and `keys_tried`.
  - If `key_first > key_last`, goes directly to DONE with `exhausted` = 1 and never asserts `dp_start`.
  - Otherwise loads `dp_key = key_first`, sets `dp_start` = 1 and goes to RUN.
- **RUN.** Waits for `dp_done`. When it is seen, on the next edge:
  - `dp_done_ack` = 1, `dp_start` = 0, `keys_tried` increments.
  - If `dp_pass` is high: `found` = 1, `key_found = dp_key`, go to DONE. A pass wins over abort and over last-key.
  - Otherwise, if abort is pending: `aborted` = 1, go to DONE.
  - Otherwise, if `{1'b0,dp_key} + STRIDE > {1'b0,key_last}` (computed at KEY_WIDTH+1 bits, so there is no wrap): `exhausted` = 1, go to DONE.
  - Otherwise go to RELEASE.
- **RELEASE.**
  - Waits for `dp_done` to go low.
  - When it is low: `dp_key += STRIDE`, `dp_start` = 1, go to RUN.
  - An abort pending here goes straight to DONE with `aborted` = 1, with no further launch.
- **DONE.**
  - Holds `done` and all results.
  - Returns to IDLE when `start` is low. `done` drops; results hold until the next accepted start.
- **Abort.** A pulse in RUN or RELEASE sets an internal pending flag, which is cleared on entry to IDLE. `abort` is ignored in IDLE and DONE.
- **Reset mid-operation.** Immediate return to IDLE with all outputs cleared. The datapath is reset on the same net.

## Timing

- Start to launch: with `start` high at edge 0, `dp_start` = 1 and `dp_key = key_first` after edge 1.
- If `dp_done` is first high at edge k:
  - `dp_done_ack` is high for exactly the cycle after edge k+1.
  - `dp_start` is low after edge k+1.
- With a datapath that drops `dp_done` one cycle after the ack, the next key launches after edge k+3.
- Per-key overhead is therefore 3 cycles plus the datapath latency.
- Result latency: `done` and the results are valid after edge k+1 of the terminating key.
- `dp_key` is stable while `dp_start` is high.
- `dp_done_ack` never lasts more than one cycle per `dp_done` assertion.

## Test plan

1. KEY_WIDTH = 8, STRIDE = 1, first = 3, last = 6; model datapath with latency 5 that passes at key 5 → keys 3, 4, 5 launched; `found` = 1, `key_found` = 5, `keys_tried` = 3, `exhausted` = 0.
2. first = 0, last = 3, never passes → 4 launches; `exhausted` = 1, `found` = 0, `keys_tried` = 4; `done` holds until `start` drops, then IDLE.
3. STRIDE = 4, first = 250, last = 255, no pass → keys 250 and 254 only, with no wrap to 2; `exhausted` = 1, `keys_tried` = 2.
4. first = 9, last = 2 → `done` one cycle after accept; `dp_start` never high; `exhausted` = 1, `keys_tried` = 0.
5. Abort pulse during key 1 of first = 0, last = 100 → key 1 completes and is acked; `aborted` = 1, `keys_tried` = 2. Repeat with `dp_pass` = 1 on that key → `found` = 1, `aborted` = 0.
6. Assert `reset` during RUN at key 7 → all outputs 0 within the cycle. Then re-start with first = 0, last = 1 → normal 2-key run; `exhausted` = 1.
